// File: rtl/pixel_line_drain.sv
// pixel_line_drain: pops out-of-order {x, depth} entries from the engine result
// FIFO, reorders them through a one-line buffer and streams pixels in raster
// order with end-of-line (m_last) and start-of-frame (m_sof) markers.
// Optional feature: define PIXEL_DRAIN_COLOUR_EN to emit 24-bit RGB instead of
// the raw depth.
module pixel_line_drain #(
  parameter int DATA_WIDTH  = 20,
  parameter int X_WIDTH     = 10,
  parameter int DEPTH_WIDTH = 10,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int MAX_ITER    = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   m_valid,
  input  logic                   m_ready,
`ifdef PIXEL_DRAIN_COLOUR_EN
  output logic [23:0]            m_data,
`else
  output logic [DEPTH_WIDTH-1:0] m_data,
`endif
  output logic                   m_last,
  output logic                   m_sof,
  output logic                   err_range
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
`ifdef PIXEL_DRAIN_COLOUR_EN
  localparam int PIX_W = 24;
`else
  localparam int PIX_W = DEPTH_WIDTH;
`endif

  logic [DEPTH_WIDTH-1:0] line_mem [WIDTH];
  logic [WIDTH-1:0]       vld;

  logic                   pend;
  logic                   hold_valid;
  logic [DATA_WIDTH-1:0]  hold_data;

  logic [IDX_W-1:0]       out_x;
  logic [Y_W-1:0]         out_y;

  logic [DATA_WIDTH-1:0]  entry;
  logic [X_WIDTH-1:0]     entry_x;
  logic [DEPTH_WIDTH-1:0] entry_depth;
  logic [IDX_W-1:0]       entry_idx;
  logic                   in_range;
  logic                   stall;
  logic                   commit;
  logic                   drop;
  logic                   load;
  logic                   out_last;
  logic                   out_first;

  // Depth-to-pixel mapping, applied as the output register loads.
  function automatic logic [PIX_W-1:0] map_pixel(input logic [DEPTH_WIDTH-1:0] depth);
`ifdef PIXEL_DRAIN_COLOUR_EN
    logic [7:0] d;
    d = depth[7:0];
    if (depth == DEPTH_WIDTH'(MAX_ITER)) return 24'h000000;
    return {d, d, ~d};
`else
    return depth;
`endif
  endfunction

  // Decode the pending entry (held copy takes priority) and derive pop/commit controls.
  always_comb begin
    entry       = hold_valid ? hold_data : fifo_data;
    entry_x     = entry[DATA_WIDTH-1:DEPTH_WIDTH];
    entry_depth = entry[DEPTH_WIDTH-1:0];
    entry_idx   = entry_x[IDX_W-1:0];
    in_range    = ({1'b0, entry_x} < (X_WIDTH+1)'(WIDTH));
    stall       = pend && in_range && vld[entry_idx];
    commit      = pend && in_range && !vld[entry_idx];
    drop        = pend && !in_range;
    fifo_rd_en  = !reset && !fifo_empty && !stall;
    load        = vld[out_x] && (!m_valid || m_ready);
    out_last    = (out_x == IDX_W'(WIDTH-1));
    out_first   = (out_x == '0) && (out_y == '0);
  end

  // Input pipeline: track the in-flight entry, keep a blocked one, flag bad x.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= 1'b0;
      hold_valid <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      pend       <= fifo_rd_en || stall;
      hold_valid <= stall;
      if (stall) hold_data <= entry;
      if (drop) err_range <= 1'b1;
    end
  end

  // Slot valid bits: set by a committed write, cleared when the output stage takes the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      if (commit) vld[entry_idx] <= 1'b1;
      if (load) vld[out_x] <= 1'b0;
    end
  end

  // Line buffer storage; validity lives in vld so the data needs no reset.
  always_ff @(posedge clk) begin
    if (commit) line_mem[entry_idx] <= entry_depth;
  end

  // Output register and raster position; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_sof   <= 1'b0;
      out_x   <= '0;
      out_y   <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= map_pixel(line_mem[out_x]);
      m_last  <= out_last;
      m_sof   <= out_first;
      if (out_last) begin
        out_x <= '0;
        out_y <= (out_y == Y_W'(HEIGHT-1)) ? '0 : out_y + 1'b1;
      end else begin
        out_x <= out_x + 1'b1;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
